// File: rtl/game_pkg.sv
// Shared types and constants for the 2048 game controller.
package game_pkg;

  localparam int BOARD_TILE_W = 12;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [3:0][3:0][BOARD_TILE_W-1:0] board_t;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_WAIT, S_RUN, S_COMMIT, S_SPAWN, S_CHECK, S_WIN, S_LOSE
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/game_sequencer_tile_spawner.sv
// Spawn probe-count constant shared with the sequencer; the spawner itself is in tile_spawner.sv.
package game_sequencer_tile_spawner_pkg;
  localparam int SPAWN_PROBES = 16;
endpackage

// File: rtl/tile_spawner.sv
// Free-running LFSR plus a linear probe that places a 2 or 4 in the first empty cell.
module tile_spawner import game_pkg::*; #(
  parameter int          TILE_W    = 12,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_spawn,
  input  logic                          abort,
  input  logic [3:0][3:0][TILE_W-1:0]   board,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [3:0]                    wr_idx,
  output logic [TILE_W-1:0]             wr_val
);

  logic [15:0] lfsr;
  logic [3:0]  idx;
  logic [3:0]  probes;
  logic        scanning;
  logic        empty;

  assign empty = (board[idx[3:2]][idx[1:0]] == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr     <= LFSR_SEED;
      idx      <= '0;
      probes   <= '0;
      scanning <= 1'b0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (abort) begin
        scanning <= 1'b0;
      end else if (start_spawn && !scanning) begin
        scanning <= 1'b1;
        idx      <= lfsr[3:0];
        probes   <= '0;
      end else if (scanning) begin
        // A full board is given up on after the 16th probe
        if (empty || probes == 4'd15) begin
          scanning <= 1'b0;
        end else begin
          idx    <= idx + 4'd1;
          probes <= probes + 4'd1;
        end
      end
    end
  end

  always_comb begin
    busy   = scanning;
    done   = scanning && !abort && (empty || probes == 4'd15);
    found  = scanning && !abort && empty;
    wr_idx = idx;
    wr_val = (lfsr[7:4] == 4'h0) ? TILE_W'(4) : TILE_W'(2);
  end

endmodule

// File: rtl/game_sequencer.sv
// Move sequencer for the 2048 datapath: owns the board, drives game_logic, spawns tiles.
module game_sequencer import game_pkg::*; #(
  parameter int          LOGIC_CYCLES = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          TILE_W       = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [3:0]                    btn_dir,
  input  logic [3:0]                    goal_sw,
  input  logic [3:0][3:0][TILE_W-1:0]   logic_matrix_D,
  input  logic [1:0]                    logic_wl,
  output logic                          logic_enable,
  output logic [3:0]                    logic_direction,
  output logic [3:0]                    logic_goal,
  output logic [3:0][3:0][TILE_W-1:0]   board,
  output logic                          busy,
  output logic                          win,
  output logic                          lose,
  output logic [15:0]                   move_count
);

  localparam int CNT_W = $clog2(LOGIC_CYCLES + 1);

  state_t                        state, next_state;
  logic [CNT_W-1:0]              run_cnt;
  logic [3:0][3:0][TILE_W-1:0]   staging;
  logic [1:0]                    wl_q;
  logic [1:0]                    spawn_left;
  logic                          from_init;
  logic                          dir_ok;
  logic                          last_run;
  logic                          start_spawn;
  logic                          sp_busy, sp_done, sp_found;
  logic [3:0]                    sp_idx;
  logic [TILE_W-1:0]             sp_val;

  assign dir_ok   = (btn_dir == DIR_UP) || (btn_dir == DIR_DOWN) ||
                    (btn_dir == DIR_LEFT) || (btn_dir == DIR_RIGHT);
  assign last_run = (run_cnt == CNT_W'(LOGIC_CYCLES - 1));
  assign busy     = !(state inside {S_IDLE, S_WAIT, S_WIN, S_LOSE});

  tile_spawner #(.TILE_W(TILE_W), .LFSR_SEED(LFSR_SEED)) u_spawner (
    .clk         (clk),
    .rst         (rst),
    .start_spawn (start_spawn),
    .abort       (start),
    .board       (board),
    .busy        (sp_busy),
    .done        (sp_done),
    .found       (sp_found),
    .wr_idx      (sp_idx),
    .wr_val      (sp_val)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // start overrides everything, including an enable pulse in flight
  always_comb begin
    next_state   = state;
    logic_enable = 1'b0;
    start_spawn  = 1'b0;
    if (start) begin
      next_state = S_INIT;
    end else begin
      case (state)
        S_INIT:   next_state = S_SPAWN;
        S_WAIT:   if (dir_ok) next_state = S_RUN;
        S_RUN: begin
          logic_enable = 1'b1;
          if (last_run) next_state = S_COMMIT;
        end
        S_COMMIT: next_state = (staging != board) ? S_SPAWN : S_CHECK;
        S_SPAWN: begin
          start_spawn = !sp_busy;
          if (sp_done && spawn_left == 2'd1)
            next_state = from_init ? S_WAIT : S_CHECK;
        end
        S_CHECK: begin
          if (wl_q[1])      next_state = S_WIN;
          else if (wl_q[0]) next_state = S_LOSE;
          else              next_state = S_WAIT;
        end
        default:  next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board           <= '0;
      move_count      <= '0;
      win             <= 1'b0;
      lose            <= 1'b0;
      logic_goal      <= '0;
      logic_direction <= '0;
      run_cnt         <= '0;
      staging         <= '0;
      wl_q            <= '0;
      spawn_left      <= '0;
      from_init       <= 1'b0;
    end else if (!start) begin
      case (state)
        S_INIT: begin
          board      <= '0;
          move_count <= '0;
          win        <= 1'b0;
          lose       <= 1'b0;
          logic_goal <= goal_sw;
          spawn_left <= 2'd2;
          from_init  <= 1'b1;
        end
        S_WAIT: begin
          if (dir_ok) begin
            logic_direction <= btn_dir;
            run_cnt         <= '0;
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt + CNT_W'(1);
          if (last_run) begin
            staging <= logic_matrix_D;
            wl_q    <= logic_wl;
          end
        end
        S_COMMIT: begin
          if (staging != board) begin
            board      <= staging;
            if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
            spawn_left <= 2'd1;
            from_init  <= 1'b0;
          end
        end
        S_SPAWN: begin
          if (sp_done) begin
            if (sp_found) board[sp_idx[3:2]][sp_idx[1:0]] <= sp_val;
            spawn_left <= spawn_left - 2'd1;
          end
        end
        S_CHECK: begin
          if (wl_q[1])      win  <= 1'b1;
          else if (wl_q[0]) lose <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
